// File: rtl/rlc_ctrl_pkg.sv
// rtl/rlc_ctrl_pkg.sv - shared types and real-valued helpers for the PI current regulator
//
// Contents:
//   ctrl_state_t : compute FSM states (IDLE, WAIT, SAMPLE, RAMP, CALC, CLAMP, OUTPUT)
//   clamp()      : saturate a value into [lo, hi]
//   slew()       : move cur toward tgt by at most step; lands exactly on tgt when within reach
package rlc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    SAMPLE = 3'd2,
    RAMP   = 3'd3,
    CALC   = 3'd4,
    CLAMP  = 3'd5,
    OUTPUT = 3'd6
  } ctrl_state_t;

  function automatic real clamp(real v, real lo, real hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic real slew(real cur, real tgt, real step);
    if ((tgt - cur) > step) return cur + step;
    if ((cur - tgt) > step) return cur - step;
    return tgt;
  endfunction

endpackage

// File: rtl/rlc_sample_timer.sv
// rtl/rlc_sample_timer.sv - control-sample divider producing one tick every CLK_DIV clocks
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : count enable; while low the divider is held at 0
//   tick  : high during the cycle in which the divider sits at CLK_DIV-1
module rlc_sample_timer #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int          CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Gated by en so a tick never leaks out on the cycle the regulator is disabled.
  assign tick = en && (r_cnt == CNT_MAX);

endmodule

// File: rtl/rlc_pi_drive.sv
// rtl/rlc_pi_drive.sv - sampled-data PI current regulator driving the RLC plant input
//
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   en         : regulator enable (level); low forces IDLE and zeroes all state
//   i_ref      : current setpoint (A)
//   i_meas     : measured plant current (A)
//   u          : plant drive voltage (V), zero-order held between samples
//   sample_stb : one-cycle pulse coinciding with each update of u
//   sat        : the most recent u was clamped
//   busy       : FSM is in SAMPLE, RAMP, CALC, CLAMP or OUTPUT
module rlc_pi_drive
  import rlc_ctrl_pkg::*;
#(
  parameter int  CLK_DIV  = 1000,
  parameter real KP       = 2.0,
  parameter real KI       = 1000.0,
  parameter real TS       = 0.000001,
  parameter real U_MAX    = 10.0,
  parameter real U_MIN    = -10.0,
  parameter real DREF_MAX = 1.0e9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  real  i_ref,
  input  real  i_meas,
  output real  u,
  output logic sample_stb,
  output logic sat,
  output logic busy
);

  generate
    if (CLK_DIV < 6) begin : g_bad_clk_div
      $fatal(1, "rlc_pi_drive: CLK_DIV must be at least 6");
    end
    if (U_MIN > U_MAX) begin : g_bad_clamp
      $fatal(1, "rlc_pi_drive: U_MIN must not exceed U_MAX");
    end
  endgenerate

  // Integral gain folded with the sample period once at elaboration.
  localparam real KI_TS = KI * TS;

  ctrl_state_t r_state;
  ctrl_state_t w_state_nxt;

  logic w_tick;
  logic w_busy;
  logic w_do_sample;
  logic w_do_ramp;
  logic w_do_calc;
  logic w_do_clamp;
  logic w_do_output;

  real r_ref_lat;
  real r_meas_lat;
  real r_ref_eff;
  real r_err;
  real r_p;
  real r_integ_cand;
  real r_integ;
  real r_v;
  real r_sat_pend;
  real r_u;
  logic r_sat;
  logic r_stb;

  real  w_err;
  real  w_v;
  logic w_clamped;
  logic w_unwinding;

  rlc_sample_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (w_tick)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = WAIT;
        WAIT:    if (w_tick) w_state_nxt = SAMPLE;
        SAMPLE:  w_state_nxt = RAMP;
        RAMP:    w_state_nxt = CALC;
        CALC:    w_state_nxt = CLAMP;
        CLAMP:   w_state_nxt = OUTPUT;
        OUTPUT:  w_state_nxt = WAIT;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // Datapath strobes are qualified by en so a sample in flight is dropped the
  // moment the regulator is disabled.
  always_comb begin
    w_busy      = 1'b0;
    w_do_sample = 1'b0;
    w_do_ramp   = 1'b0;
    w_do_calc   = 1'b0;
    w_do_clamp  = 1'b0;
    w_do_output = 1'b0;
    case (r_state)
      SAMPLE: begin w_busy = 1'b1; w_do_sample = en; end
      RAMP:   begin w_busy = 1'b1; w_do_ramp   = en; end
      CALC:   begin w_busy = 1'b1; w_do_calc   = en; end
      CLAMP:  begin w_busy = 1'b1; w_do_clamp  = en; end
      OUTPUT: begin w_busy = 1'b1; w_do_output = en; end
      default: ;
    endcase
  end

  // ---------------- datapath combinational terms ----------------
  always_comb begin
    w_err       = r_ref_eff - r_meas_lat;
    w_v         = r_p + r_integ_cand;
    w_clamped   = (w_v > U_MAX) || (w_v < U_MIN);
    // Integrating this error moves the unclamped sum back toward the legal range.
    w_unwinding = ((w_v > U_MAX) && (r_err < 0.0)) || ((w_v < U_MIN) && (r_err > 0.0));
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_lat    <= 0.0;
      r_meas_lat   <= 0.0;
      r_ref_eff    <= 0.0;
      r_err        <= 0.0;
      r_p          <= 0.0;
      r_integ_cand <= 0.0;
      r_integ      <= 0.0;
      r_v          <= 0.0;
      r_sat_pend   <= 0.0;
      r_u          <= 0.0;
      r_sat        <= 1'b0;
      r_stb        <= 1'b0;
    end else if (!en) begin
      r_ref_eff    <= 0.0;
      r_integ      <= 0.0;
      r_integ_cand <= 0.0;
      r_u          <= 0.0;
      r_sat        <= 1'b0;
      r_stb        <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (w_do_sample) begin
        r_ref_lat  <= i_ref;
        r_meas_lat <= i_meas;
      end
      if (w_do_ramp) begin
        r_ref_eff <= slew(r_ref_eff, r_ref_lat, DREF_MAX);
      end
      if (w_do_calc) begin
        r_err        <= w_err;
        r_p          <= KP * w_err;
        r_integ_cand <= r_integ + KI_TS * w_err;
      end
      if (w_do_clamp) begin
        r_v        <= clamp(w_v, U_MIN, U_MAX);
        r_sat_pend <= w_clamped ? 1.0 : 0.0;
        if (!w_clamped || w_unwinding) begin
          r_integ <= r_integ_cand;
        end
      end
      if (w_do_output) begin
        r_u   <= r_v;
        r_sat <= (r_sat_pend != 0.0);
        r_stb <= 1'b1;
      end
    end
  end

  assign u          = r_u;
  assign sample_stb = r_stb;
  assign sat        = r_sat;
  assign busy       = w_busy;

endmodule

// File: tb/tb_rlc_pi_drive.sv
// tb/tb_rlc_pi_drive.sv - directed self-checking bench for the PI current regulator
module tb_rlc_pi_drive;

  logic clk = 1'b0;
  logic rst_n;
  logic en_a, en_b, en_c;
  real  ref_a, meas_a, ref_b, meas_b, ref_c, meas_c;
  real  u_a, u_b, u_c;
  logic stb_a, stb_b, stb_c;
  logic sat_a, sat_b, sat_c;
  logic busy_a, busy_b, busy_c;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  // Default parameters.
  rlc_pi_drive dut_a (
    .clk (clk), .rst_n (rst_n), .en (en_a),
    .i_ref (ref_a), .i_meas (meas_a),
    .u (u_a), .sample_stb (stb_a), .sat (sat_a), .busy (busy_a)
  );

  // Ramp-limited reference.
  rlc_pi_drive #(.DREF_MAX (0.25)) dut_b (
    .clk (clk), .rst_n (rst_n), .en (en_b),
    .i_ref (ref_b), .i_meas (meas_b),
    .u (u_b), .sample_stb (stb_b), .sat (sat_b), .busy (busy_b)
  );

  // Minimum divider, pure proportional: exact clamp boundaries.
  rlc_pi_drive #(.CLK_DIV (6), .KI (0.0)) dut_c (
    .clk (clk), .rst_n (rst_n), .en (en_c),
    .i_ref (ref_c), .i_meas (meas_c),
    .u (u_c), .sample_stb (stb_c), .sat (sat_c), .busy (busy_c)
  );

  function automatic bit near(real a, real b);
    return ((a - b) < 1.0e-9) && ((b - a) < 1.0e-9);
  endfunction

  function automatic logic stb_of(int which);
    case (which)
      0:       return stb_a;
      1:       return stb_b;
      default: return stb_c;
    endcase
  endfunction

  task automatic chk_real(input string tag, input real obs, input real exp);
    checks++;
    assert (near(obs, exp) === 1'b1)
    else begin
      failures++;
      $error("FAIL %s observed=%.9f expected=%.9f", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts falling edges until the selected strobe is seen; -1 when the budget expires.
  task automatic wait_stb(input int which, input int budget, output int cnt);
    cnt = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (stb_of(which) === 1'b1) begin
        cnt = k;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    ref_a = 0.0; meas_a = 0.0;
    ref_b = 0.0; meas_b = 0.0;
    ref_c = 0.0; meas_c = 0.0;
    repeat (3) @(negedge clk);

    chk_real("reset_u", u_a, 0.0);
    chk_bit ("reset_stb", stb_a, 1'b0);
    chk_bit ("reset_sat", sat_a, 1'b0);
    chk_bit ("reset_busy", busy_a, 1'b0);

    rst_n = 1'b1;
    @(negedge clk);

    // Basic step: err=1 -> p=2, integ 0.001 per sample.
    ref_a = 1.0; meas_a = 0.0; en_a = 1'b1;
    wait_stb(0, 1100, n);
    chk_int ("first_latency", n, 1005);
    chk_real("first_u", u_a, 2.001);
    chk_bit ("first_sat", sat_a, 1'b0);
    chk_bit ("wait_busy", busy_a, 1'b0);
    @(negedge clk);
    chk_bit ("stb_single", stb_a, 1'b0);
    chk_real("zoh_hold", u_a, 2.001);
    wait_stb(0, 1100, n);
    chk_int ("period", n, 999);
    chk_real("second_u", u_a, 2.002);

    // Disable while in CALC: sample discarded, outputs zeroed next clock.
    repeat (997) @(negedge clk);
    chk_bit ("calc_busy", busy_a, 1'b1);
    en_a = 1'b0;
    @(negedge clk);
    chk_real("abort_u", u_a, 0.0);
    chk_bit ("abort_stb", stb_a, 1'b0);
    chk_bit ("abort_busy", busy_a, 1'b0);
    wait_stb(0, 20, n);
    chk_int ("abort_no_stb", n, -1);
    en_a = 1'b1;
    wait_stb(0, 1100, n);
    chk_int ("reenable_latency", n, 1005);
    chk_real("reenable_u", u_a, 2.001);

    // Saturation with anti-windup: v=20.01 clamps, integrator must stay 0.
    en_a = 1'b0;
    @(negedge clk);
    ref_a = 10.0; meas_a = 0.0; en_a = 1'b1;
    wait_stb(0, 1100, n);
    chk_int ("sat1_latency", n, 1005);
    chk_real("sat1_u", u_a, 10.0);
    chk_bit ("sat1_sat", sat_a, 1'b1);
    wait_stb(0, 1100, n);
    chk_real("sat2_u", u_a, 10.0);
    chk_bit ("sat2_sat", sat_a, 1'b1);
    wait_stb(0, 1100, n);
    chk_real("sat3_u", u_a, 10.0);
    chk_bit ("sat3_sat", sat_a, 1'b1);
    meas_a = 12.0;
    wait_stb(0, 1100, n);
    chk_int ("unwind_period", n, 1000);
    chk_real("unwind_u", u_a, -4.002);
    chk_bit ("unwind_sat", sat_a, 1'b0);
    meas_a = 0.0;
    wait_stb(0, 1100, n);
    chk_real("resat_u", u_a, 10.0);
    chk_bit ("resat_sat", sat_a, 1'b1);

    // Asynchronous reset in the OUTPUT cycle.
    repeat (999) @(negedge clk);
    chk_bit ("output_busy", busy_a, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_real("async_rst_u", u_a, 0.0);
    chk_bit ("async_rst_sat", sat_a, 1'b0);
    chk_bit ("async_rst_busy", busy_a, 1'b0);
    @(negedge clk);
    en_a = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp-limited reference: 0.25 A per sample toward 1.0 A.
    ref_b = 1.0; meas_b = 0.0; en_b = 1'b1;
    wait_stb(1, 1100, n);
    chk_int ("ramp_latency", n, 1005);
    chk_real("ramp1_u", u_b, 0.50025);
    wait_stb(1, 1100, n);
    chk_real("ramp2_u", u_b, 1.00075);
    wait_stb(1, 1100, n);
    chk_real("ramp3_u", u_b, 1.5015);
    wait_stb(1, 1100, n);
    chk_real("ramp4_u", u_b, 2.0025);
    en_b = 1'b0;

    // Exact clamp boundaries with CLK_DIV=6.
    ref_c = 5.0; meas_c = 0.0; en_c = 1'b1;
    wait_stb(2, 40, n);
    chk_int ("min_div_latency", n, 11);
    chk_real("edge_hi_u", u_c, 10.0);
    chk_bit ("edge_hi_sat", sat_c, 1'b0);
    ref_c = 5.5;
    wait_stb(2, 40, n);
    chk_int ("min_div_period", n, 6);
    chk_real("over_hi_u", u_c, 10.0);
    chk_bit ("over_hi_sat", sat_c, 1'b1);
    ref_c = -5.0;
    wait_stb(2, 40, n);
    chk_real("edge_lo_u", u_c, -10.0);
    chk_bit ("edge_lo_sat", sat_c, 1'b0);
    ref_c = -6.0;
    wait_stb(2, 40, n);
    chk_real("over_lo_u", u_c, -10.0);
    chk_bit ("over_lo_sat", sat_c, 1'b1);
    en_c = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
